// File: rtl/bekleme_istasyonu_pkg.sv
// Shared defaults and types for the reservation station; the register file and
// CDB arbiter import the same width defaults so tags and data agree.
package bekleme_istasyonu_pkg;

   localparam int unsigned GIRDI_SAYISI_V = 4;
   localparam int unsigned ISLEM_W_V      = 5;
   localparam int unsigned ETIKET_W_V     = 4;
   localparam int unsigned VERI_W_V       = 32;

   typedef enum logic {
      YURUT_BOS  = 1'b0,
      YURUT_DOLU = 1'b1
   } yurut_durum_t;

endpackage

// File: rtl/bekleme_istasyonu_if.sv
// Dispatch, CDB and issue bundle between rename/regfile, CDB and the station.
interface bekleme_istasyonu_if
   import bekleme_istasyonu_pkg::*;
#(
   parameter int unsigned ISLEM_W  = ISLEM_W_V,
   parameter int unsigned ETIKET_W = ETIKET_W_V,
   parameter int unsigned VERI_W   = VERI_W_V
) ();

   logic                dagit_gecerli_i;
   logic                dagit_hazir_o;
   logic [ISLEM_W-1:0]  dagit_islem_i;
   logic [VERI_W-1:0]   dagit_veri1_i;
   logic [VERI_W-1:0]   dagit_veri2_i;
   logic                dagit_veri1_gecerli_i;
   logic                dagit_veri2_gecerli_i;
   logic [ETIKET_W-1:0] dagit_veri1_etiket_i;
   logic [ETIKET_W-1:0] dagit_veri2_etiket_i;
   logic [ETIKET_W-1:0] dagit_hedef_etiket_i;

   logic                cdb_gecerli_i;
   logic [ETIKET_W-1:0] cdb_etiket_i;
   logic [VERI_W-1:0]   cdb_veri_i;

   logic                yurut_gecerli_o;
   logic                yurut_hazir_i;
   logic [ISLEM_W-1:0]  yurut_islem_o;
   logic [VERI_W-1:0]   yurut_veri1_o;
   logic [VERI_W-1:0]   yurut_veri2_o;
   logic [ETIKET_W-1:0] yurut_hedef_etiket_o;

   modport master (
      output dagit_gecerli_i, dagit_islem_i, dagit_veri1_i, dagit_veri2_i,
             dagit_veri1_gecerli_i, dagit_veri2_gecerli_i,
             dagit_veri1_etiket_i, dagit_veri2_etiket_i, dagit_hedef_etiket_i,
             cdb_gecerli_i, cdb_etiket_i, cdb_veri_i, yurut_hazir_i,
      input  dagit_hazir_o, yurut_gecerli_o, yurut_islem_o, yurut_veri1_o,
             yurut_veri2_o, yurut_hedef_etiket_o
   );

   modport slave (
      input  dagit_gecerli_i, dagit_islem_i, dagit_veri1_i, dagit_veri2_i,
             dagit_veri1_gecerli_i, dagit_veri2_gecerli_i,
             dagit_veri1_etiket_i, dagit_veri2_etiket_i, dagit_hedef_etiket_i,
             cdb_gecerli_i, cdb_etiket_i, cdb_veri_i, yurut_hazir_i,
      output dagit_hazir_o, yurut_gecerli_o, yurut_islem_o, yurut_veri1_o,
             yurut_veri2_o, yurut_hedef_etiket_o
   );

endinterface

// File: rtl/bekleme_istasyonu_oncelik_secici.sv
// Lowest-index one-hot priority encoder: isolates the least significant set bit.
module oncelik_secici #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] istek,
   output logic [W-1:0] sec_c
);

   assign sec_c = istek & (~istek + W'(1));

endmodule

// File: rtl/bekleme_istasyonu.sv
// Tomasulo reservation station: captures dispatched micro-ops, wakes operands
// from the CDB and issues the lowest-index ready entry into a registered output.
module bekleme_istasyonu
   import bekleme_istasyonu_pkg::*;
#(
   parameter int unsigned GIRDI_SAYISI = GIRDI_SAYISI_V,
   parameter int unsigned ISLEM_W      = ISLEM_W_V,
   parameter int unsigned ETIKET_W     = ETIKET_W_V,
   parameter int unsigned VERI_W       = VERI_W_V
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                temizle_i,
   bekleme_istasyonu_if.slave                  bus,
   output logic [$clog2(GIRDI_SAYISI+1)-1:0]   doluluk_o
);

   localparam int unsigned DW = $clog2(GIRDI_SAYISI + 1);

   typedef struct packed {
      logic [VERI_W-1:0]   veri;
      logic                hazir;
      logic [ETIKET_W-1:0] etiket;
   } isleneni_t;

   typedef struct packed {
      logic                gecerli;
      logic [ISLEM_W-1:0]  islem;
      isleneni_t           k1;
      isleneni_t           k2;
      logic [ETIKET_W-1:0] hedef;
   } girdi_t;

   // A waiting operand whose producer tag is on the CDB takes the broadcast value.
   function automatic isleneni_t uyandir(input isleneni_t k,
                                         input logic cdb_g,
                                         input logic [ETIKET_W-1:0] cdb_t,
                                         input logic [VERI_W-1:0] cdb_v);
      isleneni_t s;
      s = k;
      if (!k.hazir && cdb_g && (k.etiket == cdb_t)) begin
         s.veri  = cdb_v;
         s.hazir = 1'b1;
      end
      return s;
   endfunction

   girdi_t              girdi_q [GIRDI_SAYISI];
   girdi_t              girdi_d [GIRDI_SAYISI];
   girdi_t              yeni_girdi;
   logic [DW-1:0]       doluluk_q, doluluk_d;
   yurut_durum_t        durum_q, durum_d;

   logic [ISLEM_W-1:0]  yurut_islem_q;
   logic [VERI_W-1:0]   yurut_veri1_q, yurut_veri2_q;
   logic [ETIKET_W-1:0] yurut_hedef_q;

   logic [GIRDI_SAYISI-1:0] bos, uygun, bos_sec_c, uygun_sec_c;
   logic                    dagit_hazir_c, dagit_ates_c, uygun_var_c, yukle_c;

   logic [ISLEM_W-1:0]  sec_islem;
   logic [VERI_W-1:0]   sec_veri1, sec_veri2;
   logic [ETIKET_W-1:0] sec_hedef;

   always_comb begin
      for (int i = 0; i < GIRDI_SAYISI; i++) begin
         bos[i]   = !girdi_q[i].gecerli;
         uygun[i] = girdi_q[i].gecerli && girdi_q[i].k1.hazir && girdi_q[i].k2.hazir;
      end
   end

   oncelik_secici #(.W(GIRDI_SAYISI)) u_bos_secici (
      .istek (bos),
      .sec_c (bos_sec_c)
   );

   oncelik_secici #(.W(GIRDI_SAYISI)) u_uygun_secici (
      .istek (uygun),
      .sec_c (uygun_sec_c)
   );

   assign dagit_hazir_c = (doluluk_q < DW'(GIRDI_SAYISI));
   assign dagit_ates_c  = bus.dagit_gecerli_i && dagit_hazir_c && !temizle_i;
   assign uygun_var_c   = |uygun;
   assign yukle_c       = uygun_var_c && ((durum_q == YURUT_BOS) || bus.yurut_hazir_i);

   // Incoming entry, with same-cycle CDB bypass on operands not yet final.
   always_comb begin
      yeni_girdi         = '0;
      yeni_girdi.gecerli = 1'b1;
      yeni_girdi.islem   = bus.dagit_islem_i;
      yeni_girdi.hedef   = bus.dagit_hedef_etiket_i;
      yeni_girdi.k1      = uyandir('{veri: bus.dagit_veri1_i, hazir: bus.dagit_veri1_gecerli_i,
                                     etiket: bus.dagit_veri1_etiket_i},
                                   bus.cdb_gecerli_i, bus.cdb_etiket_i, bus.cdb_veri_i);
      yeni_girdi.k2      = uyandir('{veri: bus.dagit_veri2_i, hazir: bus.dagit_veri2_gecerli_i,
                                     etiket: bus.dagit_veri2_etiket_i},
                                   bus.cdb_gecerli_i, bus.cdb_etiket_i, bus.cdb_veri_i);
   end

   always_comb begin
      for (int i = 0; i < GIRDI_SAYISI; i++) begin
         girdi_d[i] = girdi_q[i];
         if (girdi_q[i].gecerli) begin
            girdi_d[i].k1 = uyandir(girdi_q[i].k1, bus.cdb_gecerli_i, bus.cdb_etiket_i, bus.cdb_veri_i);
            girdi_d[i].k2 = uyandir(girdi_q[i].k2, bus.cdb_gecerli_i, bus.cdb_etiket_i, bus.cdb_veri_i);
         end
         if (yukle_c && uygun_sec_c[i]) begin
            girdi_d[i].gecerli = 1'b0;
         end
         if (dagit_ates_c && bos_sec_c[i]) begin
            girdi_d[i] = yeni_girdi;
         end
      end
      doluluk_d = doluluk_q + DW'(dagit_ates_c) - DW'(yukle_c);
   end

   // Payload of the selected entry; the select vector is one-hot or zero.
   always_comb begin
      sec_islem = '0;
      sec_veri1 = '0;
      sec_veri2 = '0;
      sec_hedef = '0;
      for (int i = 0; i < GIRDI_SAYISI; i++) begin
         if (uygun_sec_c[i]) begin
            sec_islem = girdi_q[i].islem;
            sec_veri1 = girdi_q[i].k1.veri;
            sec_veri2 = girdi_q[i].k2.veri;
            sec_hedef = girdi_q[i].hedef;
         end
      end
   end

   always_comb begin
      durum_d = durum_q;
      if (yukle_c) begin
         durum_d = YURUT_DOLU;
      end else if (bus.yurut_hazir_i) begin
         durum_d = YURUT_BOS;
      end
   end

   // Reset outranks flush; both discard every entry and the output register.
   always_ff @(posedge clk_i) begin
      if (!rst_i || temizle_i) begin
         for (int i = 0; i < GIRDI_SAYISI; i++) begin
            girdi_q[i] <= '0;
         end
         doluluk_q     <= '0;
         durum_q       <= YURUT_BOS;
         yurut_islem_q <= '0;
         yurut_veri1_q <= '0;
         yurut_veri2_q <= '0;
         yurut_hedef_q <= '0;
      end else begin
         girdi_q   <= girdi_d;
         doluluk_q <= doluluk_d;
         durum_q   <= durum_d;
         if (yukle_c) begin
            yurut_islem_q <= sec_islem;
            yurut_veri1_q <= sec_veri1;
            yurut_veri2_q <= sec_veri2;
            yurut_hedef_q <= sec_hedef;
         end
      end
   end

   assign bus.dagit_hazir_o        = dagit_hazir_c;
   assign bus.yurut_gecerli_o      = (durum_q == YURUT_DOLU);
   assign bus.yurut_islem_o        = yurut_islem_q;
   assign bus.yurut_veri1_o        = yurut_veri1_q;
   assign bus.yurut_veri2_o        = yurut_veri2_q;
   assign bus.yurut_hedef_etiket_o = yurut_hedef_q;
   assign doluluk_o                = doluluk_q;

endmodule

// File: tb/tb_bekleme_istasyonu.sv
// Directed bench for bekleme_istasyonu with hand-computed expectations.
module tb_bekleme_istasyonu;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       temizle = 1'b0;
   logic [2:0] doluluk;
   int         toplam = 0;
   int         hata   = 0;

   always #5 clk = ~clk;

   bekleme_istasyonu_if #(.ISLEM_W(5), .ETIKET_W(4), .VERI_W(32)) bus ();

   bekleme_istasyonu #(
      .GIRDI_SAYISI (4),
      .ISLEM_W      (5),
      .ETIKET_W     (4),
      .VERI_W       (32)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .temizle_i (temizle),
      .bus       (bus),
      .doluluk_o (doluluk)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      toplam++;
      assert (obs === exp) else begin
         hata++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic dagit(input logic [4:0] op,
                        input logic [31:0] v1, input logic g1, input logic [3:0] t1,
                        input logic [31:0] v2, input logic g2, input logic [3:0] t2,
                        input logic [3:0] h);
      bus.dagit_gecerli_i       = 1'b1;
      bus.dagit_islem_i         = op;
      bus.dagit_veri1_i         = v1;
      bus.dagit_veri1_gecerli_i = g1;
      bus.dagit_veri1_etiket_i  = t1;
      bus.dagit_veri2_i         = v2;
      bus.dagit_veri2_gecerli_i = g2;
      bus.dagit_veri2_etiket_i  = t2;
      bus.dagit_hedef_etiket_i  = h;
   endtask

   task automatic cdb(input logic [3:0] t, input logic [31:0] v);
      bus.cdb_gecerli_i = 1'b1;
      bus.cdb_etiket_i  = t;
      bus.cdb_veri_i    = v;
   endtask

   task automatic bos_birak();
      bus.dagit_gecerli_i = 1'b0;
      bus.cdb_gecerli_i   = 1'b0;
      temizle             = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      dagit(0, 0, 0, 0, 0, 0, 0, 0);
      bos_birak();
      cdb(0, 0);
      bus.cdb_gecerli_i = 1'b0;
      bus.yurut_hazir_i = 1'b1;

      // reset state
      tick(); tick();
      rst = 1'b1;
      chk("rst_dol", 32'(doluluk), 0);
      chk("rst_gec", 32'(bus.yurut_gecerli_o), 0);
      chk("rst_hazir", 32'(bus.dagit_hazir_o), 1);
      chk("rst_v1", bus.yurut_veri1_o, 0);
      chk("rst_hedef", 32'(bus.yurut_hedef_etiket_o), 0);

      // both operands ready: issue after the second edge
      dagit(3, 32'h11, 1, 0, 32'h22, 1, 0, 5);
      tick(); bos_birak();
      chk("t1_dol1", 32'(doluluk), 1);
      chk("t1_gec0", 32'(bus.yurut_gecerli_o), 0);
      tick();
      chk("t1_gec1", 32'(bus.yurut_gecerli_o), 1);
      chk("t1_islem", 32'(bus.yurut_islem_o), 3);
      chk("t1_v1", bus.yurut_veri1_o, 32'h11);
      chk("t1_v2", bus.yurut_veri2_o, 32'h22);
      chk("t1_hedef", 32'(bus.yurut_hedef_etiket_o), 5);
      chk("t1_dol0", 32'(doluluk), 0);
      tick();
      chk("t1_drain", 32'(bus.yurut_gecerli_o), 0);

      // operand 1 waits on tag 7
      dagit(4, 0, 0, 7, 32'h33, 1, 0, 6);
      tick(); bos_birak();
      tick();
      chk("t2_wait_a", 32'(bus.yurut_gecerli_o), 0);
      tick();
      chk("t2_wait_b", 32'(bus.yurut_gecerli_o), 0);
      chk("t2_dol", 32'(doluluk), 1);
      cdb(7, 32'hDEAD);
      tick(); bos_birak();
      chk("t2_cap_gec0", 32'(bus.yurut_gecerli_o), 0);
      tick();
      chk("t2_gec1", 32'(bus.yurut_gecerli_o), 1);
      chk("t2_v1", bus.yurut_veri1_o, 32'hDEAD);
      chk("t2_v2", bus.yurut_veri2_o, 32'h33);
      chk("t2_hedef", 32'(bus.yurut_hedef_etiket_o), 6);
      tick();
      chk("t2_drain", 32'(bus.yurut_gecerli_o), 0);
      chk("t2_dol0", 32'(doluluk), 0);

      // same-cycle bypass from the CDB
      dagit(5, 0, 0, 9, 32'h44, 1, 0, 2);
      cdb(9, 32'hBEEF);
      tick(); bos_birak();
      chk("t3_dol", 32'(doluluk), 1);
      tick();
      chk("t3_gec1", 32'(bus.yurut_gecerli_o), 1);
      chk("t3_v1", bus.yurut_veri1_o, 32'hBEEF);
      chk("t3_v2", bus.yurut_veri2_o, 32'h44);
      chk("t3_hedef", 32'(bus.yurut_hedef_etiket_o), 2);
      tick();
      chk("t3_drain", 32'(bus.yurut_gecerli_o), 0);

      // fill, block, wake entries 1 and 3 together, hold
      bus.yurut_hazir_i = 1'b0;
      dagit(10, 0, 0, 1, 32'h100, 1, 0, 8);   tick();
      dagit(11, 0, 0, 2, 0, 0, 15, 9);        tick();
      dagit(12, 0, 0, 3, 32'h102, 1, 0, 10);  tick();
      dagit(13, 0, 0, 4, 0, 0, 15, 11);       tick();
      chk("t4_dol4", 32'(doluluk), 4);
      chk("t4_full", 32'(bus.dagit_hazir_o), 0);
      dagit(14, 32'h1, 1, 0, 32'h2, 1, 0, 12);
      tick(); bos_birak();
      chk("t4_ignored", 32'(doluluk), 4);
      chk("t4_noissue", 32'(bus.yurut_gecerli_o), 0);
      cdb(4, 32'h444); tick();
      cdb(2, 32'h222); tick();
      chk("t4_half", 32'(bus.yurut_gecerli_o), 0);
      cdb(15, 32'hF0F); tick(); bos_birak();
      chk("t4_wake_gec0", 32'(bus.yurut_gecerli_o), 0);
      tick();
      chk("t4_gec1", 32'(bus.yurut_gecerli_o), 1);
      chk("t4_islem1", 32'(bus.yurut_islem_o), 11);
      chk("t4_v1", bus.yurut_veri1_o, 32'h222);
      chk("t4_v2", bus.yurut_veri2_o, 32'hF0F);
      chk("t4_hedef1", 32'(bus.yurut_hedef_etiket_o), 9);
      chk("t4_dol3", 32'(doluluk), 3);
      chk("t4_hazir1", 32'(bus.dagit_hazir_o), 1);
      tick(); tick();
      chk("t4_hold_gec", 32'(bus.yurut_gecerli_o), 1);
      chk("t4_hold_islem", 32'(bus.yurut_islem_o), 11);
      chk("t4_hold_dol", 32'(doluluk), 3);
      bus.yurut_hazir_i = 1'b1;
      tick();
      chk("t4_islem3", 32'(bus.yurut_islem_o), 13);
      chk("t4_v1_3", bus.yurut_veri1_o, 32'h444);
      chk("t4_hedef3", 32'(bus.yurut_hedef_etiket_o), 11);
      chk("t4_dol2", 32'(doluluk), 2);
      tick();
      chk("t4_drain", 32'(bus.yurut_gecerli_o), 0);

      // flush alongside dispatch; old tags afterwards do nothing
      bus.yurut_hazir_i = 1'b0;
      dagit(21, 32'hA1, 1, 0, 32'hA2, 1, 0, 12); tick();
      chk("t5_dol3", 32'(doluluk), 3);
      dagit(22, 32'hB1, 1, 0, 32'hB2, 1, 0, 13); tick();
      chk("t5_gec1", 32'(bus.yurut_gecerli_o), 1);
      chk("t5_islem", 32'(bus.yurut_islem_o), 21);
      chk("t5_dol3b", 32'(doluluk), 3);
      dagit(23, 32'hC1, 1, 0, 32'hC2, 1, 0, 14);
      temizle = 1'b1;
      tick(); bos_birak();
      chk("t5_fl_dol", 32'(doluluk), 0);
      chk("t5_fl_gec", 32'(bus.yurut_gecerli_o), 0);
      chk("t5_fl_islem", 32'(bus.yurut_islem_o), 0);
      chk("t5_fl_hazir", 32'(bus.dagit_hazir_o), 1);
      tick();
      chk("t5_lost", 32'(bus.yurut_gecerli_o), 0);
      cdb(1, 32'h1111); tick();
      cdb(3, 32'h3333); tick(); bos_birak();
      tick();
      chk("t5_oldtag_gec", 32'(bus.yurut_gecerli_o), 0);
      chk("t5_oldtag_dol", 32'(doluluk), 0);

      // reset with two entries valid and the output pending
      dagit(1, 32'h5, 1, 0, 32'h6, 1, 0, 1); tick();
      dagit(2, 32'h7, 1, 0, 32'h8, 1, 0, 2); tick();
      dagit(3, 32'h9, 1, 0, 32'hA, 1, 0, 3); tick(); bos_birak();
      chk("t6_dol2", 32'(doluluk), 2);
      chk("t6_gec1", 32'(bus.yurut_gecerli_o), 1);
      chk("t6_islem", 32'(bus.yurut_islem_o), 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("t6_dol0", 32'(doluluk), 0);
      chk("t6_gec0", 32'(bus.yurut_gecerli_o), 0);
      chk("t6_islem0", 32'(bus.yurut_islem_o), 0);
      chk("t6_v1_0", bus.yurut_veri1_o, 0);
      chk("t6_hedef0", 32'(bus.yurut_hedef_etiket_o), 0);
      chk("t6_hazir", 32'(bus.dagit_hazir_o), 1);
      bus.yurut_hazir_i = 1'b1;
      tick();
      chk("t6_nopartial", 32'(bus.yurut_gecerli_o), 0);

      $display("test done: total=%0d bad=%0d", toplam, hata);
      $finish;
   end

endmodule
